line_point_gen: RTL and testbench
=================================

# line_point_gen

Turns a fitted line back into pixel coordinates. It accepts an intercept/slope pair in the fixed-point format produced by the linear-regression fit: intercept integer, slope scaled by 2^8. It then sweeps x across a configured range and streams one (x, y) point per handshake, using incremental accumulation. Downstream drawing and overlay logic consumes the stream to render or test against the fitted line.

## Interface
Parameters:
- X_START, 0, first x emitted (unsigned, fits 11 bits)
- X_END, 1023, last x emitted; X_END >= X_START required
- X_STEP, 1, x increment per point (>= 1)
- Y_MAX, 767, largest on-screen y
- FRAC, 8, fractional bits of slope input

Ports (one clock; reset is synchronous and active-high):
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- a_in  in  18 signed  intercept (integer pixels)
- b_in  in  31 signed  slope, Q(FRAC) fixed point (value / 2^FRAC)
- valid_in  in  1  a_in/b_in valid; accepted only in IDLE
- ready_in  in  1  downstream ready for current point
- x_out  out  11  x coordinate of current point
- y_out  out  10  clamped y coordinate
- on_screen_out  out  1  unclamped y within [0, Y_MAX]
- valid_out  out  1  point valid
- last_out  out  1  current point is final point of sweep (x_out == last x reached)
- busy_out  out  1  high in LOAD and RUN

## Operation
- States: IDLE, LOAD, RUN.
- IDLE: busy_out = 0, valid_out = 0. On valid_in, latch a_in and b_in, then go to LOAD.
- LOAD (1 cycle):
  - acc <= (a << FRAC) + b*X_START and step <= b*X_STEP, both signed with width 48 bits.
  - x_cur <= X_START.
  - Go to RUN with first point presented.
- RUN:
  - Present x_out = x_cur and ynum = acc >>> FRAC (arithmetic shift, i.e. floor).
  - Clamp: ynum < 0 gives y_out = 0, on_screen_out = 0. ynum > Y_MAX gives y_out = Y_MAX, on_screen_out = 0. Otherwise y_out = ynum[9:0], on_screen_out = 1.
  - last_out = 1 when x_cur + X_STEP > X_END.
  - Handshake is valid_out && ready_in. On a handshake that is not last: acc += step, x_cur += X_STEP, next point presented next cycle.
  - On the last handshake: valid_out falls next cycle and the state goes to IDLE.
- Outputs are registered and remain stable while valid_out && !ready_in. No change is allowed until the handshake.
- valid_in in LOAD or RUN is ignored; the new pair is dropped, and no queueing is done.
- Arithmetic: no overflow in the 48-bit acc for all legal inputs. x_cur never wraps, because the sweep terminates before x exceeds X_END.

## Timing
- Reset values: x_out = 0, y_out = 0, on_screen_out = 0, valid_out = 0, last_out = 0, busy_out = 0; state = IDLE.
- valid_in sampled high in IDLE at cycle t: LOAD at t+1, first valid_out = 1 at t+2.
- Throughput is one point per cycle when ready_in is held high. Point count N = floor((X_END − X_START)/X_STEP) + 1.
- With ready_in held high, the last point is at t+1+N and valid_out = 0 at t+2+N. valid_in is accepted again from t+2+N.
- busy_out is high from t+1 through the cycle of the last handshake.
- rst_in mid-sweep: all outputs take reset values the next cycle, state returns to IDLE, and the sweep is abandoned.
- If rst_in and valid_in are asserted together, reset wins.

## Test plan
- Unit slope: X_START=0, X_END=3, a=100, b=256, ready_in=1 → points (0,100),(1,101),(2,102),(3,103), all on_screen=1, last_out only on x=3, first valid 2 cycles after valid_in.
- Half slope with floor: a=50, b=128, X 0..3 → y = 50,50,51,51.
- Negative slope and clamp: a=10, b=−512, X 0..6 → y = 10,8,6,4,2,0 with on_screen=1, then x=6 gives y_out=0 with on_screen=0. A large-intercept case a=800, b=0 → y_out=767, on_screen=0.
- Backpressure: unit-slope case with ready_in low for 3 cycles on point x=1 → x_out/y_out/valid_out/last_out held stable (1,101) for all 3 cycles, then the sequence resumes unchanged.
- Busy drop: valid_in pulsed with a=0 while in RUN of a sweep with a=100 → that sweep completes with a=100 values, and no second sweep starts.
- Reset mid-sweep: rst_in at the third point → next cycle all outputs are 0 and busy_out=0. A new valid_in then produces a correct fresh sweep from X_START.

Source files
------------

// File: rtl/line_point_gen.sv
// Sweeps x over [X_START, X_END] and streams (x, y = a + b*x) points from a fitted line.
// Latency: first point 2 cycles after valid_in; then one point per handshake. Outputs hold while !ready_in.
module line_point_gen #(
    parameter int unsigned X_START = 0,
    parameter int unsigned X_END   = 1023,
    parameter int unsigned X_STEP  = 1,
    parameter int unsigned Y_MAX   = 767,
    parameter int unsigned FRAC    = 8
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic signed [17:0] a_in,
    input  logic signed [30:0] b_in,
    input  logic               valid_in,
    input  logic               ready_in,
    output logic [10:0]        x_out,
    output logic [9:0]         y_out,
    output logic               on_screen_out,
    output logic               valid_out,
    output logic               last_out,
    output logic               busy_out
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    localparam logic signed [47:0] X_START_S = 48'(X_START);
    localparam logic signed [47:0] X_STEP_S  = 48'(X_STEP);
    localparam logic signed [47:0] Y_MAX_S   = 48'(Y_MAX);
    localparam logic [31:0]        X_END_W   = 32'(X_END);
    localparam logic [31:0]        X_STEP_W  = 32'(X_STEP);

    state_t             state, state_nxt;
    logic signed [17:0] a_lat;
    logic signed [30:0] b_lat;
    logic signed [47:0] acc, acc_nxt;
    logic signed [47:0] step, step_nxt;
    logic [10:0]        x_cur, x_nxt;
    logic               vld_nxt;

    logic signed [47:0] a_ext, b_ext, ynum;
    logic [31:0]        x_step_sum;
    logic               last_nxt, on_nxt;
    logic [9:0]         y_nxt;

    assign a_ext    = 48'(a_lat);
    assign b_ext    = 48'(b_lat);
    assign busy_out = (state != IDLE);

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        step_nxt  = step;
        x_nxt     = x_cur;
        vld_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in) state_nxt = LOAD;
            end
            LOAD: begin
                acc_nxt   = (a_ext <<< FRAC) + b_ext * X_START_S;
                step_nxt  = b_ext * X_STEP_S;
                x_nxt     = 11'(X_START);
                vld_nxt   = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                vld_nxt = 1'b1;
                if (ready_in) begin
                    if (last_out) begin
                        vld_nxt   = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        acc_nxt = acc + step;
                        x_nxt   = x_cur + 11'(X_STEP);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output registers are fed from the next-state values so they update in step with acc/x_cur.
    always_comb begin
        ynum       = acc_nxt >>> FRAC;
        x_step_sum = {21'd0, x_nxt} + X_STEP_W;
        last_nxt   = vld_nxt && (x_step_sum > X_END_W);
        y_nxt      = ynum[9:0];
        on_nxt     = 1'b1;
        if (ynum[47]) begin
            y_nxt  = 10'd0;
            on_nxt = 1'b0;
        end else if (ynum > Y_MAX_S) begin
            y_nxt  = 10'(Y_MAX);
            on_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= IDLE;
            a_lat         <= '0;
            b_lat         <= '0;
            acc           <= '0;
            step          <= '0;
            x_cur         <= '0;
            x_out         <= '0;
            y_out         <= '0;
            on_screen_out <= 1'b0;
            valid_out     <= 1'b0;
            last_out      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && valid_in) begin
                a_lat <= a_in;
                b_lat <= b_in;
            end
            acc       <= acc_nxt;
            step      <= step_nxt;
            x_cur     <= x_nxt;
            valid_out <= vld_nxt;
            last_out  <= last_nxt;
            if (vld_nxt) begin
                x_out         <= x_nxt;
                y_out         <= y_nxt;
                on_screen_out <= on_nxt;
            end
        end
    end

endmodule

// File: tb/tb_line_point_gen.sv
// Directed bench for line_point_gen: table of sweeps plus backpressure, busy-drop and reset sequences.
module tb_line_point_gen;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic               rst_in;
    logic signed [17:0] a_in;
    logic signed [30:0] b_in;
    logic               valid0, valid1, ready_in, sel;

    logic [10:0] x0, x1, ox;
    logic [9:0]  y0, y1, oy;
    logic        on0, on1, oon, v0, v1, ov, l0, l1, ol, b0, b1, ob;

    line_point_gen #(.X_START(0), .X_END(3), .X_STEP(1), .Y_MAX(767), .FRAC(8)) u_dut0 (
        .clk_in(clk_in), .rst_in(rst_in), .a_in(a_in), .b_in(b_in),
        .valid_in(valid0), .ready_in(ready_in), .x_out(x0), .y_out(y0),
        .on_screen_out(on0), .valid_out(v0), .last_out(l0), .busy_out(b0));

    line_point_gen #(.X_START(0), .X_END(6), .X_STEP(1), .Y_MAX(767), .FRAC(8)) u_dut1 (
        .clk_in(clk_in), .rst_in(rst_in), .a_in(a_in), .b_in(b_in),
        .valid_in(valid1), .ready_in(ready_in), .x_out(x1), .y_out(y1),
        .on_screen_out(on1), .valid_out(v1), .last_out(l1), .busy_out(b1));

    assign ox  = sel ? x1  : x0;
    assign oy  = sel ? y1  : y0;
    assign oon = sel ? on1 : on0;
    assign ov  = sel ? v1  : v0;
    assign ol  = sel ? l1  : l0;
    assign ob  = sel ? b1  : b0;

    // on[k] / y[k] describe point k of the sweep.
    typedef struct packed {
        logic               sel;
        logic signed [17:0] a;
        logic signed [30:0] b;
        logic [3:0]         n;
        logic [6:0][9:0]    y;
        logic [6:0]         on;
    } vec_t;

    vec_t vecs [6];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input int s, input int a, input int b, input int n,
                           input int ya, input int yb, input int yc, input int yd,
                           input int ye, input int yf, input int yg, input logic [6:0] on);
        vecs[idx].sel  = s[0];
        vecs[idx].a    = 18'(a);
        vecs[idx].b    = 31'(b);
        vecs[idx].n    = 4'(n);
        vecs[idx].y[0] = 10'(ya);
        vecs[idx].y[1] = 10'(yb);
        vecs[idx].y[2] = 10'(yc);
        vecs[idx].y[3] = 10'(yd);
        vecs[idx].y[4] = 10'(ye);
        vecs[idx].y[5] = 10'(yf);
        vecs[idx].y[6] = 10'(yg);
        vecs[idx].on   = on;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".x"},    int'(ox),  0);
        chk({tag, ".y"},    int'(oy),  0);
        chk({tag, ".on"},   int'(oon), 0);
        chk({tag, ".vld"},  int'(ov),  0);
        chk({tag, ".last"}, int'(ol),  0);
        chk({tag, ".busy"}, int'(ob),  0);
    endtask

    task automatic check_pt(input int vi, input int k);
        vec_t v;
        v = vecs[vi];
        chk($sformatf("v%0d.p%0d.vld", vi, k),  int'(ov),  1);
        chk($sformatf("v%0d.p%0d.x", vi, k),    int'(ox),  k);
        chk($sformatf("v%0d.p%0d.y", vi, k),    int'(oy),  int'(v.y[k]));
        chk($sformatf("v%0d.p%0d.on", vi, k),   int'(oon), int'(v.on[k]));
        chk($sformatf("v%0d.p%0d.last", vi, k), int'(ol),  (k == int'(v.n) - 1) ? 1 : 0);
        chk($sformatf("v%0d.p%0d.busy", vi, k), int'(ob),  1);
    endtask

    task automatic run_sweep(input int vi, input int stall_k, input int drop_k);
        vec_t v;
        v = vecs[vi];
        @(negedge clk_in);
        sel = v.sel; a_in = v.a; b_in = v.b; ready_in = 1'b1;
        if (v.sel) valid1 = 1'b1; else valid0 = 1'b1;
        @(negedge clk_in);
        valid0 = 1'b0; valid1 = 1'b0;
        chk($sformatf("v%0d.load.vld", vi), int'(ov), 0);
        chk($sformatf("v%0d.load.busy", vi), int'(ob), 1);
        for (int k = 0; k < int'(v.n); k++) begin
            @(negedge clk_in);
            valid0 = 1'b0; valid1 = 1'b0; a_in = v.a;
            check_pt(vi, k);
            if (k == stall_k) begin
                ready_in = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk_in);
                    check_pt(vi, k);
                end
                ready_in = 1'b1;
            end
            if (k == drop_k) begin
                a_in = 18'sd0;
                if (v.sel) valid1 = 1'b1; else valid0 = 1'b1;
            end
        end
        @(negedge clk_in);
        chk($sformatf("v%0d.end.vld", vi), int'(ov), 0);
        chk($sformatf("v%0d.end.busy", vi), int'(ob), 0);
        if (drop_k >= 0) begin
            for (int i = 0; i < 2; i++) begin
                @(negedge clk_in);
                chk($sformatf("v%0d.drop%0d.vld", vi, i), int'(ov), 0);
                chk($sformatf("v%0d.drop%0d.busy", vi, i), int'(ob), 0);
            end
        end
    endtask

    initial begin
        set_vec(0, 0, 100,  256, 4, 100, 101, 102, 103, 0, 0, 0, 7'b0001111);
        set_vec(1, 0,  50,  128, 4,  50,  50,  51,  51, 0, 0, 0, 7'b0001111);
        set_vec(2, 1,  10, -512, 7,  10,   8,   6,   4, 2, 0, 0, 7'b0111111);
        set_vec(3, 0, 800,    0, 4, 767, 767, 767, 767, 0, 0, 0, 7'b0000000);
        set_vec(4, 0, 767,  256, 4, 767, 767, 767, 767, 0, 0, 0, 7'b0000001);
        set_vec(5, 1,  -2,  128, 7,   0,   0,   0,   0, 0, 0, 1, 7'b1110000);

        rst_in = 1'b1; valid0 = 1'b0; valid1 = 1'b0; ready_in = 1'b1;
        a_in = '0; b_in = '0; sel = 1'b0;
        repeat (3) @(negedge clk_in);
        sel = 1'b0; #1 chk_zero("rst0");
        sel = 1'b1; #1 chk_zero("rst1");
        rst_in = 1'b0;

        for (int i = 0; i < 6; i++) run_sweep(i, -1, -1);

        run_sweep(0, 1, -1);   // stall on x=1
        run_sweep(0, -1, 1);   // second valid_in during RUN is dropped

        // Reset on the third point abandons the sweep.
        @(negedge clk_in);
        sel = 1'b0; a_in = 18'sd100; b_in = 31'sd256; valid0 = 1'b1;
        @(negedge clk_in);
        valid0 = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("midrst.pre.x", int'(ox), 2);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        chk_zero("midrst");

        // Reset beats a simultaneous valid_in.
        rst_in = 1'b1; valid0 = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0; valid0 = 1'b0;
        @(negedge clk_in);
        chk("rstvld.busy", int'(ob), 0);
        chk("rstvld.vld", int'(ov), 0);

        run_sweep(0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
